// File: rtl/ecc_reg_pkg.sv
// Shared types and code-geometry helpers for the SECDED register bank.
package ecc_reg_pkg;

    typedef enum logic [1:0] {CLEAN, PARITY, SINGLE, DOUBLE} ecc_status_t;
    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK} scrub_state_t;

    // Smallest p with 2^p >= data_w + p + 1.
    function automatic int calc_p(input int data_w);
        int p;
        p = 0;
        for (int i = 1; i <= 8; i++) begin
            if (p == 0 && (1 << i) >= data_w + i + 1) p = i;
        end
        return p;
    endfunction

    function automatic int calc_cw(input int data_w);
        return data_w + calc_p(data_w) + 1;
    endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational SECDED codec. Codeword bit i is Hamming position i; bit 0 is overall parity.
module secded_codec
    import ecc_reg_pkg::*;
#(
    parameter int  DATA_W = 8,
    localparam int P      = calc_p(DATA_W),
    localparam int CW     = calc_cw(DATA_W)
) (
    input  logic [DATA_W-1:0] enc_data,
    output logic [CW-1:0]     enc_cw,
    input  logic [CW-1:0]     dec_cw,
    output logic [DATA_W-1:0] dec_data,
    output ecc_status_t       dec_status
);

    function automatic logic [P-1:0] syndrome(input logic [CW-1:0] c);
        logic [P-1:0] s;
        s = '0;
        for (int i = 1; i < CW; i++) begin
            if (c[i]) s = s ^ P'(i);
        end
        return s;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW-1:0] c;
        logic [P-1:0]  s;
        int            j;
        c = '0;
        j = 0;
        for (int i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[j];
                j++;
            end
        end
        // Syndrome of the data-only word gives the check bits directly.
        s = syndrome(c);
        for (int k = 0; k < P; k++) c[1 << k] = s[k];
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic void decode(input  logic [CW-1:0]     c,
                                   output logic [DATA_W-1:0] d,
                                   output ecc_status_t       st);
        logic [P-1:0]  s;
        logic          pz;
        logic [CW-1:0] fixed;
        int            j;
        s     = syndrome(c);
        pz    = ^c;
        fixed = c;
        if (s == '0) begin
            st = pz ? PARITY : CLEAN;
        end else if (pz && int'(s) <= CW - 1) begin
            st       = SINGLE;
            fixed[s] = ~fixed[s];
        end else begin
            st = DOUBLE;
        end
        d = '0;
        j = 0;
        for (int i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = fixed[i];
                j++;
            end
        end
    endfunction

    assign enc_cw = encode(enc_data);

    always_comb begin
        decode(dec_cw, dec_data, dec_status);
    end

endmodule

// File: rtl/ecc_reg_bank.sv
// SECDED-protected register bank with 1-cycle read port, background scrubber and error counters.
module ecc_reg_bank
    import ecc_reg_pkg::*;
#(
    parameter int  NUM_REGS       = 100,
    parameter int  DATA_W         = 8,
    parameter int  COUNT_W        = 16,
    parameter int  SCRUB_INTERVAL = 64,
    localparam int ADDR_W         = $clog2(NUM_REGS),
    localparam int CW             = calc_cw(DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               w_en,
    input  logic [ADDR_W-1:0]  w_addr,
    input  logic [DATA_W-1:0]  w_din,
    input  logic               r_en,
    input  logic [ADDR_W-1:0]  r_addr,
    output logic               r_valid,
    output logic [DATA_W-1:0]  reg_dout,
    output logic               single_bit_err,
    output logic               double_bit_err,
    output logic               parity_bit_err,
    input  logic               scrub_en,
    input  logic               inj_en,
    input  logic [CW-1:0]      inj_mask,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] sbe_count,
    output logic [COUNT_W-1:0] dbe_count,
    output logic               dbe_seen,
    output logic [ADDR_W-1:0]  dbe_addr
);

    localparam int IW = $clog2(SCRUB_INTERVAL) + 1;

    logic [CW-1:0]      mem_q [NUM_REGS];
    logic [CW-1:0]      mem_d [NUM_REGS];
    scrub_state_t       state_q, state_d;
    logic [IW-1:0]      ivl_q, ivl_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               r_valid_q, r_valid_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               sbe_q, sbe_d, dbe_q, dbe_d, par_q, par_d;
    logic [COUNT_W-1:0] sbe_cnt_q, sbe_cnt_d, dbe_cnt_q, dbe_cnt_d;
    logic               dseen_q, dseen_d;
    logic [ADDR_W-1:0]  daddr_q, daddr_d;

    logic               r_in_range, w_in_range;
    logic [CW-1:0]      rd_cw, wr_cw, sc_cw, sc_enc;
    logic [DATA_W-1:0]  rd_dec_data, rd_data, sc_data;
    ecc_status_t        rd_dec_st, rd_st, sc_st;
    logic               do_check, do_wb, ptr_adv;
    logic               rd_sev, rd_dev, sc_sev, sc_dev;

    assign r_in_range = int'(r_addr) < NUM_REGS;
    assign w_in_range = int'(w_addr) < NUM_REGS;
    assign rd_cw      = r_in_range ? mem_q[r_addr] : '0;
    assign sc_cw      = mem_q[ptr_q];

    secded_codec #(.DATA_W(DATA_W)) u_rd_codec (
        .enc_data(w_din), .enc_cw(wr_cw),
        .dec_cw(rd_cw), .dec_data(rd_dec_data), .dec_status(rd_dec_st)
    );

    secded_codec #(.DATA_W(DATA_W)) u_sc_codec (
        .enc_data(sc_data), .enc_cw(sc_enc),
        .dec_cw(sc_cw), .dec_data(sc_data), .dec_status(sc_st)
    );

    always_comb begin
        rd_st   = rd_dec_st;
        rd_data = rd_dec_data;
        if (!r_in_range) begin
            rd_st   = DOUBLE;
            rd_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!scrub_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (ivl_q == IW'(SCRUB_INTERVAL - 1)) state_d = CHECK;
                CHECK:     state_d = (sc_st == SINGLE || sc_st == PARITY) ? WRITEBACK : IDLE;
                WRITEBACK: state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        do_check = scrub_en && state_q == CHECK;
        do_wb    = scrub_en && state_q == WRITEBACK;
        ptr_adv  = (do_check && state_d == IDLE) || do_wb;
    end

    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] c, input logic [1:0] inc);
        logic [COUNT_W:0] sum;
        sum = {1'b0, c} + (COUNT_W+1)'(inc);
        return sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
    endfunction

    always_comb begin
        ivl_d = '0;
        if (scrub_en && state_q == IDLE && ivl_q != IW'(SCRUB_INTERVAL - 1)) ivl_d = ivl_q + 1'b1;
        ptr_d = ptr_q;
        if (ptr_adv) ptr_d = (ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

        // Later assignment wins: a user write overrides a same-address writeback.
        mem_d = mem_q;
        if (do_wb) mem_d[ptr_q] = sc_enc;
        if (w_en && w_in_range) mem_d[w_addr] = wr_cw ^ (inj_en ? inj_mask : '0);

        r_valid_d = r_en;
        dout_d    = dout_q;
        sbe_d     = sbe_q;
        dbe_d     = dbe_q;
        par_d     = par_q;
        if (r_en) begin
            dout_d = rd_data;
            sbe_d  = rd_st == SINGLE;
            dbe_d  = rd_st == DOUBLE;
            par_d  = rd_st == PARITY;
        end

        rd_sev = r_en && (rd_st == SINGLE || rd_st == PARITY);
        rd_dev = r_en && rd_st == DOUBLE;
        sc_sev = do_check && (sc_st == SINGLE || sc_st == PARITY);
        sc_dev = do_check && sc_st == DOUBLE;

        sbe_cnt_d = sat_add(sbe_cnt_q, {1'b0, rd_sev} + {1'b0, sc_sev});
        dbe_cnt_d = sat_add(dbe_cnt_q, {1'b0, rd_dev} + {1'b0, sc_dev});
        dseen_d   = dseen_q;
        daddr_d   = daddr_q;
        if (!dseen_q && rd_dev) begin
            dseen_d = 1'b1;
            daddr_d = r_addr;
        end else if (!dseen_q && sc_dev) begin
            dseen_d = 1'b1;
            daddr_d = ptr_q;
        end
        if (cnt_clr) begin
            sbe_cnt_d = '0;
            dbe_cnt_d = '0;
            dseen_d   = 1'b0;
            daddr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
            ivl_q     <= '0;
            ptr_q     <= '0;
            r_valid_q <= 1'b0;
            dout_q    <= '0;
            sbe_q     <= 1'b0;
            dbe_q     <= 1'b0;
            par_q     <= 1'b0;
            sbe_cnt_q <= '0;
            dbe_cnt_q <= '0;
            dseen_q   <= 1'b0;
            daddr_q   <= '0;
        end else begin
            mem_q     <= mem_d;
            ivl_q     <= ivl_d;
            ptr_q     <= ptr_d;
            r_valid_q <= r_valid_d;
            dout_q    <= dout_d;
            sbe_q     <= sbe_d;
            dbe_q     <= dbe_d;
            par_q     <= par_d;
            sbe_cnt_q <= sbe_cnt_d;
            dbe_cnt_q <= dbe_cnt_d;
            dseen_q   <= dseen_d;
            daddr_q   <= daddr_d;
        end
    end

    assign r_valid        = r_valid_q;
    assign reg_dout       = dout_q;
    assign single_bit_err = sbe_q;
    assign double_bit_err = dbe_q;
    assign parity_bit_err = par_q;
    assign sbe_count      = sbe_cnt_q;
    assign dbe_count      = dbe_cnt_q;
    assign dbe_seen       = dseen_q;
    assign dbe_addr       = daddr_q;

endmodule

// File: tb/tb_ecc_reg_bank.sv
// Bench for ecc_reg_bank: directed scenarios plus a randomized phase against an error-count model.
module tb_ecc_reg_bank;
    import ecc_reg_pkg::*;

    localparam int NR = 100;
    localparam int DW = 8;
    localparam int CW = 13;
    localparam int AW = 7;
    localparam int SAT = 65535;

    logic          clk = 1'b0;
    logic          reset, w_en, r_en, scrub_en, inj_en, cnt_clr;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] w_din;
    logic [CW-1:0] inj_mask;
    logic          r_valid, single_bit_err, double_bit_err, parity_bit_err, dbe_seen;
    logic [DW-1:0] reg_dout;
    logic [15:0]   sbe_count, dbe_count;
    logic [AW-1:0] dbe_addr;

    ecc_reg_bank #(.NUM_REGS(NR), .DATA_W(DW), .COUNT_W(16), .SCRUB_INTERVAL(4)) dut (
        .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_din(w_din),
        .r_en(r_en), .r_addr(r_addr), .r_valid(r_valid), .reg_dout(reg_dout),
        .single_bit_err(single_bit_err), .double_bit_err(double_bit_err),
        .parity_bit_err(parity_bit_err), .scrub_en(scrub_en), .inj_en(inj_en),
        .inj_mask(inj_mask), .cnt_clr(cnt_clr), .sbe_count(sbe_count),
        .dbe_count(dbe_count), .dbe_seen(dbe_seen), .dbe_addr(dbe_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: stored data plus the set of flipped codeword positions per entry.
    logic [DW-1:0] m_data [NR];
    logic [CW-1:0] m_err  [NR];
    int            exp_sbe, exp_dbe, exp_daddr;
    bit            exp_dseen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Data bit j sits at the j-th codeword position that is not a power of two.
    function automatic logic [DW-1:0] data_flips(input logic [CW-1:0] m);
        logic [DW-1:0] f;
        int            j;
        f = '0;
        j = 0;
        for (int p = 3; p < CW; p++) begin
            if (p != 4 && p != 8) begin
                if (m[p]) f[j] = 1'b1;
                j++;
            end
        end
        return f;
    endfunction

    task automatic expect_read(input int a, output ecc_status_t st, output logic [DW-1:0] d);
        int n;
        if (a >= NR) begin
            st = DOUBLE;
            d  = '0;
        end else begin
            n = $countones(m_err[a]);
            d = m_data[a];
            if (n == 0)      st = CLEAN;
            else if (n == 1) st = m_err[a][0] ? PARITY : SINGLE;
            else begin
                st = DOUBLE;
                d  = m_data[a] ^ data_flips(m_err[a]);
            end
        end
    endtask

    task automatic count_event(input ecc_status_t st, input int a);
        if (st == SINGLE || st == PARITY) exp_sbe = (exp_sbe < SAT) ? exp_sbe + 1 : SAT;
        if (st == DOUBLE) begin
            exp_dbe = (exp_dbe < SAT) ? exp_dbe + 1 : SAT;
            if (!exp_dseen) begin
                exp_dseen = 1'b1;
                exp_daddr = a;
            end
        end
    endtask

    task automatic check_resp(input string tag, input ecc_status_t st, input logic [DW-1:0] d);
        chk({tag, ".dout"}, reg_dout, d);
        chk({tag, ".sbe"}, single_bit_err, st == SINGLE);
        chk({tag, ".dbe"}, double_bit_err, st == DOUBLE);
        chk({tag, ".par"}, parity_bit_err, st == PARITY);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, ".sbe_count"}, sbe_count, exp_sbe);
        chk({tag, ".dbe_count"}, dbe_count, exp_dbe);
        chk({tag, ".dbe_seen"}, dbe_seen, exp_dseen);
        if (exp_dseen) chk({tag, ".dbe_addr"}, dbe_addr, exp_daddr);
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic [CW-1:0] m);
        w_en = 1'b1; w_addr = AW'(a); w_din = d; inj_en = (m != '0); inj_mask = m;
        @(negedge clk);
        w_en = 1'b0; inj_en = 1'b0; inj_mask = '0;
        if (a < NR) begin
            m_data[a] = d;
            m_err[a]  = m;
        end
    endtask

    task automatic do_read(input int a, input string tag);
        ecc_status_t   st;
        logic [DW-1:0] d;
        expect_read(a, st, d);
        r_en = 1'b1; r_addr = AW'(a);
        @(negedge clk);
        r_en = 1'b0;
        count_event(st, a);
        chk({tag, ".valid"}, r_valid, 1'b1);
        check_resp(tag, st, d);
        check_counts(tag);
    endtask

    task automatic wait_sbe(input int target, input string tag);
        int n;
        n = 0;
        while (sbe_count !== 16'(target) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sbe_count, target);
    endtask

    initial begin
        ecc_status_t   st, last_st;
        logic [DW-1:0] d, last_d;
        logic [CW-1:0] m;
        int            ra, wa, p1;
        bit            rd, wr;

        reset = 1'b1; w_en = 1'b0; r_en = 1'b0; scrub_en = 1'b0; inj_en = 1'b0;
        cnt_clr = 1'b0; w_addr = '0; r_addr = '0; w_din = '0; inj_mask = '0;
        for (int i = 0; i < NR; i++) begin
            m_data[i] = '0;
            m_err[i]  = '0;
        end
        exp_sbe = 0; exp_dbe = 0; exp_dseen = 1'b0; exp_daddr = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset.valid", r_valid, 1'b0);
        check_resp("reset", CLEAN, 8'h00);
        check_counts("reset");
        chk("reset.dbe_addr", dbe_addr, 0);

        for (int a = 0; a < NR; a++) do_read(a, "rst_read");
        @(negedge clk);
        chk("idle.valid", r_valid, 1'b0);
        check_resp("idle_hold", CLEAN, 8'h00);

        do_write(7, 8'hA5, 13'h0008);
        do_read(7, "sbe7");
        chk("sbe7.count_is_1", sbe_count, 1);

        do_write(9, 8'h3C, 13'h0028);
        do_read(9, "dbe9");
        chk("dbe9.raw", reg_dout, 8'h3F);

        do_write(0, 8'h5A, 13'h0001);
        do_read(0, "par0");

        // Scrubber corrects addr 50 and revisits the double error at addr 9.
        do_write(0, 8'h5A, '0);
        do_write(7, 8'hA5, '0);
        do_write(50, 8'h5A, 13'h0040);
        scrub_en = 1'b1;
        wait_sbe(exp_sbe + 1, "scrub_reach50");
        repeat (2) @(negedge clk);
        scrub_en = 1'b0;
        @(negedge clk);
        exp_sbe = exp_sbe + 1;
        exp_dbe = exp_dbe + 1;
        m_err[50] = '0;
        check_counts("scrub_pass");
        do_read(50, "scrubbed50");
        do_read(9, "dbe9_kept");

        // Writeback collides with a user write to the same address.
        do_write(50, 8'h5A, 13'h0040);
        scrub_en = 1'b1;
        wait_sbe(exp_sbe + 1, "scrub_reach50b");
        w_en = 1'b1; w_addr = 7'd50; w_din = 8'h11;
        @(negedge clk);
        w_en = 1'b0; scrub_en = 1'b0;
        m_data[50] = 8'h11; m_err[50] = '0;
        exp_sbe = exp_sbe + 1;
        exp_dbe = exp_dbe + 1;
        @(negedge clk);
        check_counts("collide");
        do_read(50, "collide50");

        // Saturate the correctable counter.
        do_write(50, 8'h5A, 13'h0040);
        r_en = 1'b1; r_addr = 7'd50;
        repeat (65540) @(negedge clk);
        r_en = 1'b0;
        @(negedge clk);
        exp_sbe = SAT;
        chk("sat.sbe_count", sbe_count, 16'hFFFF);
        check_resp("sat", SINGLE, 8'h5A);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_sbe = 0; exp_dbe = 0; exp_dseen = 1'b0;
        check_counts("clr");

        // Randomized mix with scrubber off.
        last_st = SINGLE; last_d = 8'h5A;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rd = ($urandom_range(0, 9) < 6);
            wr = ($urandom_range(0, 1) == 1);
            ra = $urandom_range(0, 109);
            wa = $urandom_range(0, 109);
            d  = 8'($urandom);
            m  = '0;
            p1 = $urandom_range(0, CW - 1);
            case ($urandom_range(0, 2))
                1: m[p1] = 1'b1;
                2: begin
                    m[p1] = 1'b1;
                    m[(p1 + 1 + $urandom_range(0, CW - 2)) % CW] = 1'b1;
                end
                default: ;
            endcase
            r_en = rd; r_addr = AW'(ra);
            w_en = wr; w_addr = AW'(wa); w_din = d;
            inj_en = ($urandom_range(0, 3) != 0); inj_mask = m;
            if (rd) expect_read(ra, st, last_d);
            if (rd) last_st = st;
            @(negedge clk);
            if (wr && wa < NR) begin
                m_data[wa] = d;
                m_err[wa]  = inj_en ? m : '0;
            end
            r_en = 1'b0; w_en = 1'b0; inj_en = 1'b0;
            if (rd) count_event(last_st, ra);
            chk("rand.valid", r_valid, rd);
            check_resp("rand", last_st, last_d);
            check_counts("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
